axi_sram_slave: RTL and testbench

- AXI4 responder (slave) modelling a word-organised SRAM.
- Serves the LSU/IFU AXI masters: accepts AR/R and AW/W/B transactions, including single-beat and INCR/FIXED bursts.
- Applies programmable read and write response latency to stress master handshakes.
- Read and write channels run independently, each with its own FSM.

---
 rtl/axi_sram_slave.sv | 381 ++++++++++++++++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
//   AXI4 responder modelling a word-organised SRAM of DEPTH_WORDS 32-bit
//   words mapped at BASE_ADDR. Read and write channels each have their own
//   FSM and a programmable response latency. One transaction per channel is
//   in flight at a time. Bursts: FIXED holds the address, INCR and WRAP both
//   advance by 4 bytes per beat. Every beat is range-checked on its own.
//
// Ports
//   clk, rst                       clock, asynchronous active-low reset
//   aw*  (valid/ready/addr/id/len/size/burst)   write address channel
//   w*   (valid/ready/data/strb/last)           write data channel
//   b*   (valid/ready/resp/id)                  write response channel
//   ar*  (valid/ready/addr/id/len/size/burst)   read address channel
//   r*   (valid/ready/data/resp/last/id)        read data channel
// ---------------------------------------------------------------------------
module axi_sram_slave #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned RD_LATENCY  = 2,
    parameter int unsigned WR_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic [3:0]  rid
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // Computed in 33 bits so a window ending exactly at 4 GiB does not wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_e;

    function automatic logic in_range(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst);
        return (burst == 2'b00) ? a : (a + 32'd4);
    endfunction

    // Out-of-range dominates; a wlast mismatch alone is a slave error.
    function automatic logic [1:0] wr_resp(input logic oor, input logic mis);
        return oor ? 2'b11 : (mis ? 2'b10 : 2'b00);
    endfunction

    // Transfer size never changes the data returned: whole words only.
    logic unused_s;
    assign unused_s = ^{awsize, arsize};

    logic [31:0] mem_q [DEPTH_WORDS];

    // ---------------- read channel state ----------------
    r_state_e    r_state_q, r_state_d;
    logic [3:0]  r_cnt_q, r_cnt_d;
    logic [31:0] ar_addr_q, ar_addr_d;
    logic [7:0]  ar_len_q, ar_len_d;
    logic [1:0]  ar_burst_q, ar_burst_d;
    logic [7:0]  r_beat_q, r_beat_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic        rlast_q, rlast_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  rid_q, rid_d;
    logic        rd_load_s;
    logic        rd_load_last_s;
    logic [31:0] rd_load_addr_s;

    // ---------------- write channel state ----------------
    w_state_e    w_state_q, w_state_d;
    logic [3:0]  w_cnt_q, w_cnt_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [3:0]  aw_id_q, aw_id_d;
    logic [7:0]  aw_len_q, aw_len_d;
    logic [1:0]  aw_burst_q, aw_burst_d;
    logic [7:0]  w_beat_q, w_beat_d;
    logic        oor_err_q, oor_err_d;
    logic        mis_err_q, mis_err_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [3:0]  bid_q, bid_d;
    logic        w_last_beat_s;
    logic        w_oor_s;
    logic        w_mis_s;
    logic        wr_en_s;

    // Read FSM: next state, beat sequencing and registered R-channel outputs.
    always_comb begin
        r_state_d      = r_state_q;
        r_cnt_d        = r_cnt_q;
        ar_addr_d      = ar_addr_q;
        ar_len_d       = ar_len_q;
        ar_burst_d     = ar_burst_q;
        r_beat_d       = r_beat_q;
        arready_d      = arready_q;
        rvalid_d       = rvalid_q;
        rlast_d        = rlast_q;
        rid_d          = rid_q;
        rd_load_s      = 1'b0;
        rd_load_last_s = 1'b0;
        rd_load_addr_s = ar_addr_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    ar_addr_d  = araddr;
                    ar_len_d   = arlen;
                    ar_burst_d = arburst;
                    rid_d      = arid;
                    r_beat_d   = 8'd0;
                    arready_d  = 1'b0;
                    if (RD_LATENCY == 32'd0) begin
                        // No wait state: first beat loads straight from the request.
                        r_state_d      = R_DATA;
                        rvalid_d       = 1'b1;
                        rd_load_s      = 1'b1;
                        rd_load_addr_s = araddr;
                        rd_load_last_s = (arlen == 8'd0);
                    end else begin
                        r_state_d = R_WAIT;
                        r_cnt_d   = 4'(RD_LATENCY - 32'd1);
                    end
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_WAIT: begin
                if (r_cnt_q == 4'd0) begin
                    r_state_d      = R_DATA;
                    rvalid_d       = 1'b1;
                    rd_load_s      = 1'b1;
                    rd_load_addr_s = ar_addr_q;
                    rd_load_last_s = (ar_len_q == 8'd0);
                end else begin
                    r_cnt_d = r_cnt_q - 4'd1;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (r_beat_q == ar_len_q) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                    end else begin
                        r_beat_d       = r_beat_q + 8'd1;
                        ar_addr_d      = next_addr(ar_addr_q, ar_burst_q);
                        rd_load_s      = 1'b1;
                        rd_load_addr_s = next_addr(ar_addr_q, ar_burst_q);
                        rd_load_last_s = ((r_beat_q + 8'd1) == ar_len_q);
                    end
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
            end
        endcase
        // Beat data is captured at load time, so a same-cycle write is not seen.
        if (rd_load_s) begin
            rdata_d = in_range(rd_load_addr_s) ? mem_q[word_idx(rd_load_addr_s)] : 32'h0;
            rresp_d = in_range(rd_load_addr_s) ? 2'b00 : 2'b11;
            rlast_d = rd_load_last_s;
        end else begin
            rdata_d = rdata_q;
            rresp_d = rresp_q;
        end
    end

    // Write FSM: next state, error tracking and registered B-channel outputs.
    always_comb begin
        w_state_d     = w_state_q;
        w_cnt_d       = w_cnt_q;
        aw_addr_d     = aw_addr_q;
        aw_id_d       = aw_id_q;
        aw_len_d      = aw_len_q;
        aw_burst_d    = aw_burst_q;
        w_beat_d      = w_beat_q;
        oor_err_d     = oor_err_q;
        mis_err_d     = mis_err_q;
        awready_d     = awready_q;
        wready_d      = wready_q;
        bvalid_d      = bvalid_q;
        bresp_d       = bresp_q;
        bid_d         = bid_q;
        w_last_beat_s = (w_beat_q == aw_len_q);
        w_oor_s       = oor_err_q | ~in_range(aw_addr_q);
        w_mis_s       = mis_err_q | (wlast != w_last_beat_s);
        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    aw_addr_d  = awaddr;
                    aw_id_d    = awid;
                    aw_len_d   = awlen;
                    aw_burst_d = awburst;
                    w_beat_d   = 8'd0;
                    oor_err_d  = 1'b0;
                    mis_err_d  = 1'b0;
                    awready_d  = 1'b0;
                    wready_d   = 1'b1;
                    w_state_d  = W_DATA;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    oor_err_d = w_oor_s;
                    mis_err_d = w_mis_s;
                    // The beat count, not wlast, ends the data phase.
                    if (w_last_beat_s) begin
                        wready_d = 1'b0;
                        if (WR_LATENCY == 32'd0) begin
                            w_state_d = W_RESP;
                            bvalid_d  = 1'b1;
                            bresp_d   = wr_resp(w_oor_s, w_mis_s);
                            bid_d     = aw_id_q;
                        end else begin
                            w_state_d = W_WAIT;
                            w_cnt_d   = 4'(WR_LATENCY - 32'd1);
                        end
                    end else begin
                        w_beat_d  = w_beat_q + 8'd1;
                        aw_addr_d = next_addr(aw_addr_q, aw_burst_q);
                    end
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_WAIT: begin
                if (w_cnt_q == 4'd0) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_resp(oor_err_q, mis_err_q);
                    bid_d     = aw_id_q;
                end else begin
                    w_cnt_d = w_cnt_q - 4'd1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                awready_d = 1'b1;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
            end
        endcase
    end

    assign wr_en_s = (w_state_q == W_DATA) && wvalid && wready_q && in_range(aw_addr_q);

    // Byte-lane writes into the array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem_q[word_idx(aw_addr_q)][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // State and output registers for both channels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q  <= R_IDLE;
            r_cnt_q    <= 4'd0;
            ar_addr_q  <= 32'h0;
            ar_len_q   <= 8'd0;
            ar_burst_q <= 2'b00;
            r_beat_q   <= 8'd0;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= 2'b00;
            rdata_q    <= 32'h0;
            rid_q      <= 4'd0;
            w_state_q  <= W_IDLE;
            w_cnt_q    <= 4'd0;
            aw_addr_q  <= 32'h0;
            aw_id_q    <= 4'd0;
            aw_len_q   <= 8'd0;
            aw_burst_q <= 2'b00;
            w_beat_q   <= 8'd0;
            oor_err_q  <= 1'b0;
            mis_err_q  <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            bid_q      <= 4'd0;
        end else begin
            r_state_q  <= r_state_d;
            r_cnt_q    <= r_cnt_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_burst_q <= ar_burst_d;
            r_beat_q   <= r_beat_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            rid_q      <= rid_d;
            w_state_q  <= w_state_d;
            w_cnt_q    <= w_cnt_d;
            aw_addr_q  <= aw_addr_d;
            aw_id_q    <= aw_id_d;
            aw_len_q   <= aw_len_d;
            aw_burst_q <= aw_burst_d;
            w_beat_q   <= w_beat_d;
            oor_err_q  <= oor_err_d;
            mis_err_q  <= mis_err_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            bid_q      <= bid_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = bid_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
//   Self-checking bench for axi_sram_slave. Single-beat write/read pairs come
//   from a vector table; bursts, backpressure with a concurrent read, and a
//   mid-burst reset are hand-written sequences. Expected read beats are
//   pushed to a scoreboard queue from a bench-side memory model when the AR
//   request is driven and popped as the DUT hands them over.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_sram_slave;

    localparam int          RD_LAT = 2;
    localparam int          WR_LAT = 0;
    localparam int          DEPTH  = 4096;
    localparam logic [31:0] BASE   = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        awvalid = 1'b0, awready;
    logic [31:0] awaddr = 32'h0;
    logic [3:0]  awid = 4'd0;
    logic [7:0]  awlen = 8'd0;
    logic [2:0]  awsize = 3'd2;
    logic [1:0]  awburst = 2'b01;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic        wlast = 1'b0;
    logic        bvalid, bready = 1'b0;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arvalid = 1'b0, arready;
    logic [31:0] araddr = 32'h0;
    logic [3:0]  arid = 4'd0;
    logic [7:0]  arlen = 8'd0;
    logic [2:0]  arsize = 3'd2;
    logic [1:0]  arburst = 2'b01;
    logic        rvalid, rready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    always #5 clk = ~clk;

    axi_sram_slave #(
        .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;
    rbeat_t sb_q[$];

    logic [31:0] model_mem [int];

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  exp_bresp;
        logic [31:0] raddr;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;
    vec_t vec[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) &&
               (longint'(a) < longint'(BASE) + longint'(DEPTH) * 64'd4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input logic [31:0] data0, input logic [3:0] strb,
                            input int wlast_at, input int bstall, output logic [1:0] resp);
        logic [31:0] a;
        logic [31:0] w;
        logic [1:0]  exp_resp;
        bit          oor;
        bit          ok;
        int          cyc;
        a    = addr;
        oor  = 1'b0;
        resp = 2'bxx;
        awaddr = addr; awid = id; awlen = len; awburst = burst; awvalid = 1'b1;
        cyc = 0;
        do begin ok = awready; @(negedge clk); cyc++; end while (!ok && cyc < 100);
        awvalid = 1'b0;
        if (!ok) begin check("aw_timeout", 32'd0, 32'd1); return; end
        for (int b = 0; b <= int'(len); b++) begin
            wdata = data0 + 32'(b); wstrb = strb; wlast = (b == wlast_at); wvalid = 1'b1;
            cyc = 0;
            do begin ok = wready; @(negedge clk); cyc++; end while (!ok && cyc < 100);
            if (!ok) begin
                wvalid = 1'b0;
                check("w_timeout", 32'd0, 32'd1);
                return;
            end
            if (in_rng(a)) begin
                w = model_mem.exists(widx(a)) ? model_mem[widx(a)] : 32'h0;
                for (int l = 0; l < 4; l++) if (strb[l]) w[8*l +: 8] = wdata[8*l +: 8];
                model_mem[widx(a)] = w;
            end else begin
                oor = 1'b1;
            end
            if (burst != 2'b00) a = a + 32'd4;
        end
        wvalid = 1'b0; wlast = 1'b0;
        exp_resp = oor ? 2'b11 : ((wlast_at != int'(len)) ? 2'b10 : 2'b00);
        cyc = 0;
        while (!bvalid && cyc < 100) begin @(negedge clk); cyc++; end
        check("b_latency", cyc, WR_LAT);
        for (int s = 0; s < bstall; s++) begin
            check("b_hold_valid", bvalid, 1'b1);
            check("b_hold_resp", bresp, exp_resp);
            check("b_hold_id", bid, id);
            @(negedge clk);
        end
        check("bvalid", bvalid, 1'b1);
        check("bresp", bresp, exp_resp);
        check("bid", bid, id);
        resp = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_drop", bvalid, 1'b0);
        check("awready_back", awready, 1'b1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input bit toggle,
                           output logic [31:0] last_data, output logic [1:0] last_resp);
        logic [31:0] a;
        rbeat_t      e;
        bit          ok;
        int          cyc;
        int          k;
        a = addr;
        last_data = 32'hx; last_resp = 2'bxx;
        for (int b = 0; b <= int'(len); b++) begin
            e.data = in_rng(a) ? model_mem[widx(a)] : 32'h0;
            e.resp = in_rng(a) ? 2'b00 : 2'b11;
            e.last = (b == int'(len));
            e.id   = id;
            sb_q.push_back(e);
            if (burst != 2'b00) a = a + 32'd4;
        end
        araddr = addr; arid = id; arlen = len; arburst = burst; arvalid = 1'b1;
        cyc = 0;
        do begin ok = arready; @(negedge clk); cyc++; end while (!ok && cyc < 100);
        arvalid = 1'b0;
        if (!ok) begin check("ar_timeout", 32'd0, 32'd1); sb_q.delete(); return; end
        cyc = 0;
        while (!rvalid && cyc < 100) begin
            check("arready_wait", arready, 1'b0);
            @(negedge clk); cyc++;
        end
        check("rd_latency", cyc, RD_LAT);
        k = 0;
        while (sb_q.size() > 0 && k < 200) begin
            rready = toggle ? (k % 3 != 1) : 1'b1;
            if (rvalid) begin
                e = sb_q[0];
                check("rdata", rdata, e.data);
                check("rresp", rresp, e.resp);
                check("rlast", rlast, e.last);
                check("rid", rid, e.id);
                check("arready_busy", arready, 1'b0);
                if (rready) begin
                    last_data = rdata; last_resp = rresp;
                    void'(sb_q.pop_front());
                end
            end else begin
                check("rvalid_gap", rvalid, 1'b1);
            end
            @(negedge clk); k++;
        end
        rready = 1'b0;
        check("r_pending", sb_q.size(), 32'd0);
        sb_q.delete();
        check("rvalid_after", rvalid, 1'b0);
        check("arready_after", arready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  br;
        logic [1:0]  rr;
        logic [31:0] rd;
        bit          ok;
        int          cyc;

        vec[0] = '{32'h8000_0000, 32'hCAFE_0000, 4'hF,    2'b00, 32'h8000_0000, 32'hCAFE_0000, 2'b00};
        vec[1] = '{32'h8000_0010, 32'hDEAD_BEEF, 4'hF,    2'b00, 32'h8000_0010, 32'hDEAD_BEEF, 2'b00};
        vec[2] = '{32'h8000_0020, 32'h1122_3344, 4'hF,    2'b00, 32'h8000_0020, 32'h1122_3344, 2'b00};
        vec[3] = '{32'h8000_0020, 32'hAABB_CCDD, 4'b0100, 2'b00, 32'h8000_0020, 32'h11BB_3344, 2'b00};
        vec[4] = '{32'h8000_4000, 32'h1234_5678, 4'hF,    2'b11, 32'h8000_0000, 32'hCAFE_0000, 2'b00};
        vec[5] = '{32'h8000_3FFC, 32'h0BAD_F00D, 4'hF,    2'b00, 32'h8000_3FFC, 32'h0BAD_F00D, 2'b00};
        vec[6] = '{32'h8000_0033, 32'h55AA_55AA, 4'hF,    2'b00, 32'h8000_0030, 32'h55AA_55AA, 2'b00};
        vec[7] = '{32'h7FFF_FFFC, 32'h0000_0001, 4'hF,    2'b11, 32'h7FFF_FFFC, 32'h0000_0000, 2'b11};

        // Reset values
        @(negedge clk);
        check("rst_awready", awready, 1'b1);
        check("rst_arready", arready, 1'b1);
        check("rst_wready", wready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rlast", rlast, 1'b0);
        check("rst_bresp", bresp, 2'b00);
        check("rst_rresp", rresp, 2'b00);
        check("rst_rdata", rdata, 32'h0);
        check("rst_bid", bid, 4'd0);
        check("rst_rid", rid, 4'd0);
        rst = 1'b1;
        @(negedge clk);

        // Table: single-beat write then read
        for (int i = 0; i < 8; i++) begin
            do_write(vec[i].waddr, 4'(i), 8'd0, 2'b01, vec[i].wdata, vec[i].wstrb, 0, 0, br);
            check($sformatf("tbl%0d_bresp", i), br, vec[i].exp_bresp);
            do_read(vec[i].raddr, 4'(i + 8), 8'd0, 2'b01, 1'b0, rd, rr);
            check($sformatf("tbl%0d_rdata", i), rd, vec[i].exp_rdata);
            check($sformatf("tbl%0d_rresp", i), rr, vec[i].exp_rresp);
        end

        // INCR burst write 1..4 then burst read with rready 1,0,1 pattern
        do_write(BASE, 4'd1, 8'd3, 2'b01, 32'd1, 4'hF, 3, 0, br);
        check("burst_w_bresp", br, 2'b00);
        do_read(BASE, 4'd2, 8'd3, 2'b01, 1'b1, rd, rr);
        check("burst_r_last", rd, 32'd4);
        // FIXED read repeats word 1, WRAP advances like INCR
        do_read(BASE + 32'd4, 4'd4, 8'd2, 2'b00, 1'b0, rd, rr);
        check("fixed_r_last", rd, 32'd2);
        do_read(BASE, 4'd6, 8'd1, 2'b10, 1'b1, rd, rr);
        check("wrap_r_last", rd, 32'd2);
        // FIXED write: final beat wins
        do_write(BASE + 32'h200, 4'd6, 8'd2, 2'b00, 32'h10, 4'hF, 2, 0, br);
        do_read(BASE + 32'h200, 4'd7, 8'd0, 2'b01, 1'b0, rd, rr);
        check("fixed_w_data", rd, 32'h12);
        // wlast on the first beat of a two-beat burst
        do_write(BASE + 32'h300, 4'd9, 8'd1, 2'b01, 32'h77, 4'hF, 0, 0, br);
        check("wlast_mis_bresp", br, 2'b10);
        // Burst running off the top of the array
        do_write(BASE + 32'h3FFC, 4'd10, 8'd1, 2'b01, 32'hABCD_0000, 4'hF, 1, 0, br);
        check("edge_w_bresp", br, 2'b11);
        do_read(BASE + 32'h3FFC, 4'd11, 8'd1, 2'b01, 1'b0, rd, rr);
        check("edge_r_rresp", rr, 2'b11);

        // B backpressure for 5 cycles while a read proceeds
        fork
            begin
                logic [1:0] b2;
                do_write(BASE + 32'h100, 4'd3, 8'd0, 2'b01, 32'h600D_F00D, 4'hF, 0, 5, b2);
                check("par_bresp", b2, 2'b00);
            end
            begin
                logic [31:0] d2;
                logic [1:0]  r2;
                do_read(BASE + 32'h10, 4'd5, 8'd0, 2'b01, 1'b0, d2, r2);
                check("par_rdata", d2, 32'hDEAD_BEEF);
            end
        join

        // Reset during beat 2 of a 4-beat read
        araddr = BASE; arid = 4'd7; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
        cyc = 0;
        do begin ok = arready; @(negedge clk); cyc++; end while (!ok && cyc < 100);
        arvalid = 1'b0;
        cyc = 0;
        while (!rvalid && cyc < 100) begin @(negedge clk); cyc++; end
        check("rst_seq_beat1", rdata, 32'd1);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("rst_seq_beat2", rdata, 32'd2);
        rst = 1'b0;
        #1;
        check("rst_seq_rvalid", rvalid, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_seq_arready", arready, 1'b1);
        check("rst_seq_rvalid2", rvalid, 1'b0);
        do_read(BASE, 4'd8, 8'd3, 2'b01, 1'b0, rd, rr);
        check("rst_seq_retained", rd, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
